spi_flash_responder: RTL and testbench
======================================

// Module: spi_flash_responder
// PURPOSE
//  Synthesizable SPI flash target: the device end of the link driven by spi_flash_controller.
//  Oversamples SCK/CS#/MOSI in the system clock domain and answers mode-0 flash commands:
//  READ 0x03, JEDEC ID 0x9F and READ STATUS 0x05. Data comes from an external byte-wide
//  backing store with 1-cycle read latency. Used for on-board loopback and controller bring-up.
// PARAMETERS
//  ADDR_WIDTH  16          backing-store address width; low ADDR_WIDTH bits of 24-bit flash address used
//  JEDEC_ID    24'hEF4016  bytes returned by 0x9F, MSB byte first
//  STATUS_VAL  8'h00       byte returned repeatedly by 0x05 (never busy)
// PORTS
//  clk          in   1           system clock (88.67 MHz nominal)
//  reset        in   1           synchronous, active-high
//  i_SPI_CLK    in   1           SCK from master, asynchronous, idle low (mode 0)
//  i_SPI_CS     in   1           chip select, active low, asynchronous
//  i_SPI_MOSI   in   1           serial data from master, asynchronous
//  o_SPI_MISO   out  1           serial data to master
//  o_MEM_ADDR   out  ADDR_WIDTH  backing-store read address
//  o_MEM_RD     out  1           one-cycle read strobe; i_MEM_DATA valid the cycle after
//  i_MEM_DATA   in   8           backing-store read data
//  o_BUSY       out  1           high from CS# fall (synchronized) until return to IDLE
// BEHAVIOUR
//  - Reset: o_SPI_MISO=0, o_MEM_ADDR=0, o_MEM_RD=0, o_BUSY=0, state IDLE, all shift/bit counters 0.
//  - SCK, CS#, MOSI each pass a 2-flop synchronizer; edges detected on the synchronized SCK.
//    Requirement on master: SCK high and low phases each >= 4 clk periods.
//  - Mode 0: MOSI sampled on synchronized SCK rise; MISO changes only on synchronized SCK fall,
//    registered, so o_SPI_MISO updates exactly 3 clk after the SCK fall at the pin.
//  - SCK edges while CS# high are ignored.
//  - States: IDLE, CMD, ADDR, DATA, ID, STAT, IGNORE.
//    IDLE: CS# low -> CMD, bit counter 0, o_BUSY=1.
//    CMD: shift 8 bits MSB first; on 8th rise decode: 0x03->ADDR, 0x9F->ID, 0x05->STAT, else IGNORE.
//    ADDR: shift 24 bits MSB first; on 24th rise o_MEM_ADDR<=addr[ADDR_WIDTH-1:0], o_MEM_RD pulses
//      next cycle, data captured one cycle later into the load register; state -> DATA.
//      Upper address bits beyond ADDR_WIDTH are ignored.
//    DATA: on the SCK fall following the last address bit, load register -> MISO shift
//      register and MSB driven; each later fall drives next bit. On every load, o_MEM_ADDR
//      increments and a prefetch read is issued so byte N+1 is ready before its first fall.
//      Address wraps from 2^ADDR_WIDTH-1 to 0. Continues indefinitely while CS# low.
//    ID: drives JEDEC_ID bytes 2,1,0 in order from first fall after command; after 3 bytes
//      repeats from byte 2.
//    STAT: drives STATUS_VAL repeatedly, MSB first.
//    IGNORE: MOSI discarded, o_SPI_MISO=0, no memory reads.
//  - CS# rise (synchronized) in any state: abort, -> IDLE next cycle, o_SPI_MISO=0,
//    o_BUSY=0, partial command/address discarded, no further o_MEM_RD. o_MEM_ADDR holds.
//  - CS# rise and SCK edge in the same synchronized cycle: CS# wins, edge ignored.
//  - o_SPI_MISO=0 in IDLE, CMD, ADDR, IGNORE. Never tri-stated; board-level buffer owns that.
//  - reset in any state overrides all, outputs to reset values the next cycle.
//  - Exactly one o_MEM_RD pulse per byte loaded, none speculative past CS# rise.
// TESTING
//  1 Mem[0x3AAA]=0xA5, [0x3AAB]=0x3C; send 03 00 3A AA, clock 16 bits -> MISO bytes A5,3C; 2 o_MEM_RD pulses + 1 prefetch.
//  2 Send 9F, clock 32 bits -> MISO EF,40,16,EF; no o_MEM_RD.
//  3 Send 03 00 FF FF, clock 2 bytes, mem[FFFF]=11, mem[0000]=22 -> MISO 11,22; o_MEM_ADDR wraps to 0000.
//  4 Send 03 00 12 (CS# rises after 20 bits), then 05 + 8 clocks -> first frame yields no o_MEM_RD,
//    second returns 00; o_BUSY low between frames.
//  5 Send 0xAB + 16 clocks -> MISO stays 0, no o_MEM_RD; assert reset mid READ data -> all outputs reset next cycle.
//  6 Run tests 1-2 with SCK half period 4 clk and 11 clk -> identical bytes; check MISO stable at every SCK rise.

Source files
------------

// File: rtl/spi_flash_responder.sv
// SPI flash target (mode 0): oversamples SCK/CS#/MOSI in the clk domain and answers
// READ 0x03, JEDEC ID 0x9F and READ STATUS 0x05 from a byte-wide 1-cycle-latency store.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | CS# high or just fell; waiting to start a command
// ST_CMD    | shifting in the 8-bit opcode
// ST_ADDR   | shifting in the 24-bit READ address
// ST_DATA   | streaming backing-store bytes, prefetching the next one
// ST_ID     | streaming JEDEC ID bytes 2,1,0 repeatedly
// ST_STAT   | streaming STATUS_VAL repeatedly
// ST_IGNORE | unknown opcode; MOSI discarded, MISO held low
module spi_flash_responder #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
  parameter logic [7:0]  STATUS_VAL = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_SPI_CLK,
  input  logic                  i_SPI_CS,
  input  logic                  i_SPI_MOSI,
  output logic                  o_SPI_MISO,
  output logic [ADDR_WIDTH-1:0] o_MEM_ADDR,
  output logic                  o_MEM_RD,
  input  logic [7:0]            i_MEM_DATA,
  output logic                  o_BUSY
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_ID,
    ST_STAT,
    ST_IGNORE
  } state_t;

  state_t                  state_q;
  logic [1:0]              sck_sync_q;
  logic [1:0]              cs_sync_q;
  logic [1:0]              mosi_sync_q;
  logic                    sck_prev_q;
  logic [4:0]              bit_cnt_q;
  logic [23:0]             in_shift_q;
  logic [7:0]              out_shift_q;
  logic [7:0]              load_q;
  logic [1:0]              id_idx_q;
  logic                    rd_req_q;
  logic                    rd_dly_q;
  logic                    miso_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic                    mem_rd_q;
  logic                    busy_q;

  logic                    sck_s;
  logic                    cs_n_s;
  logic                    mosi_s;
  logic                    sck_rise;
  logic                    sck_fall;
  logic [23:0]             in_shift_d;
  logic [7:0]              next_byte_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_inc_d;
  logic                    unused_shift_msb;

  assign sck_s            = sck_sync_q[1];
  assign cs_n_s           = cs_sync_q[1];
  assign mosi_s           = mosi_sync_q[1];
  assign sck_rise         = sck_s & ~sck_prev_q;
  assign sck_fall         = ~sck_s & sck_prev_q;
  assign in_shift_d       = {in_shift_q[22:0], mosi_s};
  assign mem_addr_inc_d   = mem_addr_q + ADDR_WIDTH'(1);
  assign unused_shift_msb = in_shift_q[23];

  // Byte presented on the first fall of each output byte.
  always_comb begin
    next_byte_d = 8'h00;
    case (state_q)
      ST_DATA: next_byte_d = load_q;
      ST_ID: begin
        case (id_idx_q)
          2'd0:    next_byte_d = JEDEC_ID[23:16];
          2'd1:    next_byte_d = JEDEC_ID[15:8];
          default: next_byte_d = JEDEC_ID[7:0];
        endcase
      end
      ST_STAT: next_byte_d = STATUS_VAL;
      default: next_byte_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sck_sync_q  <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sck_prev_q  <= 1'b0;
      bit_cnt_q   <= 5'd0;
      in_shift_q  <= 24'd0;
      out_shift_q <= 8'd0;
      load_q      <= 8'd0;
      id_idx_q    <= 2'd0;
      rd_req_q    <= 1'b0;
      rd_dly_q    <= 1'b0;
      miso_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], i_SPI_CLK};
      cs_sync_q   <= {cs_sync_q[0], i_SPI_CS};
      mosi_sync_q <= {mosi_sync_q[0], i_SPI_MOSI};
      sck_prev_q  <= sck_s;
      rd_dly_q    <= mem_rd_q;
      if (rd_dly_q) begin
        load_q <= i_MEM_DATA;
      end

      // CS# deassertion beats any SCK edge seen in the same cycle.
      if (cs_n_s) begin
        state_q    <= ST_IDLE;
        miso_q     <= 1'b0;
        busy_q     <= 1'b0;
        rd_req_q   <= 1'b0;
        mem_rd_q   <= 1'b0;
        bit_cnt_q  <= 5'd0;
        in_shift_q <= 24'd0;
        id_idx_q   <= 2'd0;
      end else begin
        mem_rd_q <= rd_req_q;
        rd_req_q <= 1'b0;
        case (state_q)
          ST_IDLE: begin
            state_q   <= ST_CMD;
            busy_q    <= 1'b1;
            bit_cnt_q <= 5'd0;
            miso_q    <= 1'b0;
          end

          ST_CMD: begin
            if (sck_rise) begin
              in_shift_q <= in_shift_d;
              if (bit_cnt_q == 5'd7) begin
                bit_cnt_q <= 5'd0;
                id_idx_q  <= 2'd0;
                case (in_shift_d[7:0])
                  8'h03:   state_q <= ST_ADDR;
                  8'h9F:   state_q <= ST_ID;
                  8'h05:   state_q <= ST_STAT;
                  default: state_q <= ST_IGNORE;
                endcase
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end

          ST_ADDR: begin
            if (sck_rise) begin
              in_shift_q <= in_shift_d;
              if (bit_cnt_q == 5'd23) begin
                mem_addr_q <= in_shift_d[ADDR_WIDTH-1:0];
                rd_req_q   <= 1'b1;
                bit_cnt_q  <= 5'd0;
                state_q    <= ST_DATA;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end

          ST_DATA, ST_ID, ST_STAT: begin
            if (sck_fall) begin
              if (bit_cnt_q[2:0] == 3'd0) begin
                out_shift_q <= next_byte_d;
                miso_q      <= next_byte_d[7];
                if (state_q == ST_DATA) begin
                  // Prefetch so the following byte lands in load_q well before its first fall.
                  mem_addr_q <= mem_addr_inc_d;
                  rd_req_q   <= 1'b1;
                end
                if (state_q == ST_ID) begin
                  id_idx_q <= (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
                end
              end else begin
                out_shift_q <= {out_shift_q[6:0], 1'b0};
                miso_q      <= out_shift_q[6];
              end
              bit_cnt_q <= {2'b00, bit_cnt_q[2:0] + 3'd1};
            end
          end

          ST_IGNORE: begin
            miso_q <= 1'b0;
          end

          default: begin
            state_q <= ST_IDLE;
            miso_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_SPI_MISO = miso_q;
  assign o_MEM_ADDR = mem_addr_q;
  assign o_MEM_RD   = mem_rd_q;
  assign o_BUSY     = busy_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a mode-0 master model driving READ, JEDEC ID,
// STATUS, abort and unknown-opcode frames against a 1-cycle-latency memory model.
module tb_spi_flash_responder;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          sck;
  logic          cs_n;
  logic          mosi;
  logic          miso;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [7:0]    mem_data = 8'h00;
  logic          busy;

  logic [7:0]    mem [0:(1<<AW)-1];
  logic [AW-1:0] rd_log [$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            half  = 4;
  logic          unstable;

  always #5 clk = ~clk;

  spi_flash_responder #(
    .ADDR_WIDTH(AW),
    .JEDEC_ID  (24'hEF4016),
    .STATUS_VAL(8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_SPI_CLK (sck),
    .i_SPI_CS  (cs_n),
    .i_SPI_MOSI(mosi),
    .o_SPI_MISO(miso),
    .o_MEM_ADDR(mem_addr),
    .o_MEM_RD  (mem_rd),
    .i_MEM_DATA(mem_data),
    .o_BUSY    (busy)
  );

  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];
  always @(negedge clk) if (mem_rd) rd_log.push_back(mem_addr);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < rd_log.size()) return 32'(rd_log[i]);
    return 32'hDEADBEEF;
  endfunction

  task automatic spi_bit(input logic tx, output logic rx);
    sck  = 1'b0;
    mosi = tx;
    repeat (half) @(negedge clk);
    sck = 1'b1;
    rx  = miso;
    for (int k = 0; k < half; k++) begin
      @(negedge clk);
      if (miso !== rx) unstable = 1'b1;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic start_frame();
    rd_log.delete();
    unstable = 1'b0;
    cs_n = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  // Final SCK fall and CS# rise land together so no trailing byte load happens.
  task automatic end_frame();
    sck  = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_read_hdr(input logic [23:0] addr);
    logic [7:0] rx;
    spi_byte(8'h03, rx);
    spi_byte(addr[23:16], rx);
    spi_byte(addr[15:8], rx);
    spi_byte(addr[7:0], rx);
  endtask

  task automatic test_read1();
    logic [7:0] rx0, rx1;
    start_frame();
    send_read_hdr(24'h003AAA);
    sck = 1'b0;
    repeat (2) @(negedge clk);
    chk($sformatf("t1_lat_before_h%0d", half), miso, 0);
    @(negedge clk);
    chk($sformatf("t1_lat_after_h%0d", half), miso, 1);
    spi_byte(8'h00, rx0);
    spi_byte(8'h00, rx1);
    end_frame();
    chk($sformatf("t1_byte0_h%0d", half), rx0, 8'hA5);
    chk($sformatf("t1_byte1_h%0d", half), rx1, 8'h3C);
    chk($sformatf("t1_rd_count_h%0d", half), rd_log.size(), 3);
    chk($sformatf("t1_rd0_h%0d", half), log_at(0), 32'h3AAA);
    chk($sformatf("t1_rd1_h%0d", half), log_at(1), 32'h3AAB);
    chk($sformatf("t1_rd2_h%0d", half), log_at(2), 32'h3AAC);
    chk($sformatf("t1_miso_stable_h%0d", half), unstable, 0);
    chk($sformatf("t1_busy_after_h%0d", half), busy, 0);
  endtask

  task automatic test_jedec();
    logic [7:0] rx;
    logic [7:0] exp_id [4];
    logic [7:0] got [4];
    exp_id = '{8'hEF, 8'h40, 8'h16, 8'hEF};
    start_frame();
    spi_byte(8'h9F, rx);
    for (int i = 0; i < 4; i++) spi_byte(8'h00, got[i]);
    end_frame();
    for (int i = 0; i < 4; i++) chk($sformatf("t2_id%0d_h%0d", i, half), got[i], exp_id[i]);
    chk($sformatf("t2_no_rd_h%0d", half), rd_log.size(), 0);
    chk($sformatf("t2_miso_stable_h%0d", half), unstable, 0);
  endtask

  task automatic test_wrap();
    logic [7:0] rx0, rx1;
    start_frame();
    send_read_hdr(24'h00FFFF);
    spi_byte(8'h00, rx0);
    spi_byte(8'h00, rx1);
    end_frame();
    chk("t3_byte0", rx0, 8'h11);
    chk("t3_byte1", rx1, 8'h22);
    chk("t3_rd0", log_at(0), 32'hFFFF);
    chk("t3_rd1_wrapped", log_at(1), 32'h0000);
    chk("t3_rd2", log_at(2), 32'h0001);
  endtask

  task automatic test_abort_stat();
    logic [7:0] rx;
    logic       b;
    start_frame();
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    for (int i = 7; i >= 4; i--) spi_bit(rx[0] ^ rx[0] ^ ((8'h12 >> i) & 1), b);
    end_frame();
    chk("t4_abort_no_rd", rd_log.size(), 0);
    chk("t4_busy_between", busy, 0);
    start_frame();
    chk("t4_busy_in_frame", busy, 1);
    spi_byte(8'h05, rx);
    spi_byte(8'h00, rx);
    end_frame();
    chk("t4_status", rx, 8'h00);
    chk("t4_stat_no_rd", rd_log.size(), 0);
  endtask

  task automatic test_ignore_reset();
    logic [7:0] rx0, rx1;
    logic       b;
    start_frame();
    spi_byte(8'hAB, rx0);
    spi_byte(8'h00, rx0);
    spi_byte(8'h00, rx1);
    end_frame();
    chk("t5_ign_byte0", rx0, 8'h00);
    chk("t5_ign_byte1", rx1, 8'h00);
    chk("t5_ign_no_rd", rd_log.size(), 0);

    start_frame();
    send_read_hdr(24'h003AAA);
    spi_byte(8'h00, rx0);
    chk("t5_pre_byte0", rx0, 8'hA5);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, b);
    sck = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_pre_miso", miso, 1);
    chk("t5_pre_addr", mem_addr, 16'h3AAC);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_miso", miso, 0);
    chk("t5_rst_addr", mem_addr, 0);
    chk("t5_rst_rd", mem_rd, 0);
    chk("t5_rst_busy", busy, 0);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    sck   = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    mem[16'h3AAA] = 8'hA5;
    mem[16'h3AAB] = 8'h3C;
    mem[16'h3AAC] = 8'h96;
    mem[16'hFFFF] = 8'h11;
    mem[16'h0000] = 8'h22;
    mem[16'h0001] = 8'h33;
    repeat (4) @(negedge clk);
    chk("rst_miso", miso, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_busy", busy, 0);

    half = 4;
    test_read1();
    test_jedec();
    test_wrap();
    test_abort_stat();
    test_ignore_reset();
    half = 11;
    test_read1();
    test_jedec();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
